// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state, ALU-op and control-word types for multicycle_control
//
// Purpose: controller state enum, alu_control op codes, opcode classes and the
//          state-only control word with its per-state decode.
// Ports:   none (package).
package control_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_CBZ    = 4'd9,
        S_BR     = 4'd10
    } ctrl_state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_PASS  = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        OP_RTYPE   = 3'd0,
        OP_LOAD    = 3'd1,
        OP_STORE   = 3'd2,
        OP_CBZ     = 3'd3,
        OP_B       = 3'd4,
        OP_ILLEGAL = 3'd5
    } op_class_t;

    // Outputs that depend on state alone, plus one-hot state flags used to
    // build the few terms qualified by mem_ack, zero or the opcode class.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       pc_src;
        logic       reg2_loc;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       done_st;
        logic       in_fetch;
        logic       in_decode;
        logic       in_mem_wr;
        logic       in_cbz;
        logic       in_br;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input ctrl_state_t s);
        ctrl_t c;
        c = '0;
        c.alu_op = ALU_OP_ADD;
        case (s)
            S_FETCH: begin
                c.mem_req  = 1'b1;
                c.in_fetch = 1'b1;
            end
            S_DECODE: c.in_decode = 1'b1;
            S_EXEC_R: c.alu_op = ALU_OP_RTYPE;
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALU_OP_RTYPE;
                c.done_st   = 1'b1;
            end
            S_ADDR: begin
                c.alu_src  = 1'b1;
                c.reg2_loc = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.alu_src      = 1'b1;
            end
            S_WB_LD: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done_st    = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req      = 1'b1;
                c.mem_we       = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.reg2_loc     = 1'b1;
                c.alu_src      = 1'b1;
                c.in_mem_wr    = 1'b1;
            end
            S_CBZ: begin
                c.alu_op   = ALU_OP_PASS;
                c.reg2_loc = 1'b1;
                c.pc_src   = 1'b1;
                c.done_st  = 1'b1;
                c.in_cbz   = 1'b1;
            end
            S_BR: begin
                c.pc_src  = 1'b1;
                c.done_st = 1'b1;
                c.in_br   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/legv8_defs_pkg.sv
// rtl/legv8_defs_pkg.sv - shared LEGv8 opcode definitions (instruction[31:21])
//
// Purpose: one place for the 11-bit opcode values and the masked match
//          patterns of the variable-length CBZ and B opcode fields.
// Ports:   none (package).
package legv8_defs_pkg;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;

    // CBZ is 10110100xxx, B is 000101xxxxx: low bits belong to the immediate.
    localparam logic [10:0] OPC_CBZ_MASK  = 11'h7F8;
    localparam logic [10:0] OPC_CBZ_MATCH = 11'h5A0;
    localparam logic [10:0] OPC_B_MASK    = 11'h7E0;
    localparam logic [10:0] OPC_B_MATCH   = 11'h0A0;

endpackage

// File: rtl/opcode_class.sv
// rtl/opcode_class.sv - combinational LEGv8 opcode classifier
//
// Purpose: maps instruction[31:21] to RTYPE/LOAD/STORE/CBZ/B/ILLEGAL.
// Ports:   opcode   in  11  instruction[31:21]
//          op_class out 3   classification (op_class_t)
module opcode_class
    import legv8_defs_pkg::*;
    import control_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   op_class
);

    always_comb begin
        op_class = OP_ILLEGAL;
        if (opcode == OPC_ADD || opcode == OPC_SUB ||
            opcode == OPC_AND || opcode == OPC_ORR)
            op_class = OP_RTYPE;
        else if (opcode == OPC_LDUR)
            op_class = OP_LOAD;
        else if (opcode == OPC_STUR)
            op_class = OP_STORE;
        else if ((opcode & OPC_CBZ_MASK) == OPC_CBZ_MATCH)
            op_class = OP_CBZ;
        else if ((opcode & OPC_B_MASK) == OPC_B_MATCH)
            op_class = OP_B;
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - LEGv8 multicycle datapath sequencing FSM
//
// Purpose: steps fetch/decode/execute/memory/write-back, drives alu_op and
//          arbitrates the shared memory port with a req/ack handshake.
// Ports:   clk, rst_n (async active-low); opcode[10:0], zero, mem_ack in;
//          mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
//          reg2_loc, alu_src, alu_op[1:0], reg_write, mem_to_reg,
//          illegal_op, instr_done, state[3:0] out.
module multicycle_control
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2_loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal_op,
    output logic        instr_done,
    output logic [3:0]  state
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    ctrl_t       ctrl_q;
    op_class_t   op_cls;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (op_cls)
    );

    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_cls)
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_LOAD, OP_STORE: state_d = S_ADDR;
                    OP_CBZ:            state_d = S_CBZ;
                    OP_B:              state_d = S_BR;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            // The IR still holds the LDUR/STUR opcode, so reclassify here.
            S_ADDR:   state_d = (op_cls == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = mem_ack ? S_WB_LD : S_MEM_RD;
            S_WB_LD:  state_d = S_FETCH;
            S_MEM_WR: state_d = mem_ack ? S_FETCH : S_MEM_WR;
            S_CBZ:    state_d = S_FETCH;
            S_BR:     state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    // The control word is registered from the next state, so it always
    // matches state_q and the async reset clears every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_decode(state_d);
        end
    end

    assign mem_req      = ctrl_q.mem_req;
    assign mem_we       = ctrl_q.mem_we;
    assign mem_addr_sel = ctrl_q.mem_addr_sel;
    assign pc_src       = ctrl_q.pc_src;
    assign reg2_loc     = ctrl_q.reg2_loc;
    assign alu_src      = ctrl_q.alu_src;
    assign alu_op       = ctrl_q.alu_op;
    assign reg_write    = ctrl_q.reg_write;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign state        = state_q;

    // IR load and PC+4 happen on the fetch ack edge; mem_ack alone is ignored.
    assign ir_write   = ctrl_q.in_fetch & mem_ack;
    assign pc_write   = (ctrl_q.in_fetch & mem_ack) | (ctrl_q.in_cbz & zero) | ctrl_q.in_br;
    assign illegal_op = ctrl_q.in_decode & (op_cls == OP_ILLEGAL);
    assign instr_done = ctrl_q.done_st | illegal_op | (ctrl_q.in_mem_wr & mem_ack);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic        reg2_loc, alu_src, reg_write, mem_to_reg, illegal_op, instr_done;
    logic [1:0]  alu_op;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg2_loc     (reg2_loc),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .illegal_op   (illegal_op),
        .instr_done   (instr_done),
        .state        (state)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg2_loc;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal_op;
        logic       instr_done;
    } outs_t;

    outs_t obs;
    assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  reg2_loc, alu_src, alu_op, reg_write, mem_to_reg,
                  illegal_op, instr_done};

    // Debug state numbering follows the listed state order.
    localparam logic [3:0] ST_RESET = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                           ST_EXEC_R = 4'd3, ST_WB_R = 4'd4, ST_ADDR = 4'd5,
                           ST_MEM_RD = 4'd6, ST_WB_LD = 4'd7, ST_MEM_WR = 4'd8,
                           ST_CBZ = 4'd9, ST_BR = 4'd10;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Opcode classification straight from the instruction-set table.
    function automatic int classify(input logic [10:0] op);
        logic [7:0] top8;
        logic [5:0] top6;
        top8 = op[10:3];
        top6 = op[10:5];
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
        if (op == 11'h7C2) return K_LD;
        if (op == 11'h7C0) return K_ST;
        if (top8 == 8'hB4) return K_CBZ;
        if (top6 == 6'h05) return K_B;
        return K_ILL;
    endfunction

    // Entered at posedge+1: drive ack, compare at the falling edge, advance.
    task automatic step(input string tag, input logic ack, input logic [3:0] want_state,
                        input outs_t want);
        mem_ack = ack;
        @(negedge clk);
        check({tag, ".out"}, 32'(obs), 32'(want));
        check({tag, ".state"}, 32'(state), 32'(want_state));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst.async_out", 32'(obs), 32'd0);
        check("rst.async_state", 32'(state), 32'(ST_RESET));
        repeat (3) begin
            mem_ack = 1'($urandom);
            @(negedge clk);
            check("rst.hold_out", 32'(obs), 32'd0);
            check("rst.hold_state", 32'(state), 32'(ST_RESET));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rst.release", 1'($urandom), ST_RESET, '0);
    endtask

    // Plays one instruction: fw/mw are wait cycles in fetch/memory access.
    // abort_wr asserts reset partway through a stalled store.
    task automatic run_instr(input logic [10:0] opc, input int fw, input int mw,
                             input logic z, input bit abort_wr);
        outs_t e;
        int    k;
        k = classify(opc);
        opcode = 11'($urandom);
        zero   = 1'($urandom);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_req = 1'b1;
            step("fetch_wait", 1'b0, ST_FETCH, e);
        end
        e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step("fetch_ack", 1'b1, ST_FETCH, e);
        opcode = opc;
        e = '0;
        if (k == K_ILL) begin e.illegal_op = 1'b1; e.instr_done = 1'b1; end
        step("decode", 1'($urandom), ST_DECODE, e);
        case (k)
            K_R: begin
                e = '0; e.alu_op = 2'b10;
                step("exec_r", 1'($urandom), ST_EXEC_R, e);
                e = '0; e.alu_op = 2'b10; e.reg_write = 1'b1; e.instr_done = 1'b1;
                step("wb_r", 1'($urandom), ST_WB_R, e);
            end
            K_LD, K_ST: begin
                e = '0; e.alu_src = 1'b1; e.reg2_loc = 1'b1;
                step("addr", 1'($urandom), ST_ADDR, e);
                if (k == K_LD) begin
                    e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.alu_src = 1'b1;
                    for (int i = 0; i < mw; i++) step("mem_rd_wait", 1'b0, ST_MEM_RD, e);
                    step("mem_rd_ack", 1'b1, ST_MEM_RD, e);
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
                    step("wb_ld", 1'($urandom), ST_WB_LD, e);
                end else begin
                    e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
                    e.reg2_loc = 1'b1; e.alu_src = 1'b1;
                    for (int i = 0; i < mw; i++) step("mem_wr_wait", 1'b0, ST_MEM_WR, e);
                    if (abort_wr) begin
                        mem_ack = 1'b0;
                        #2;
                        rst_n = 1'b0;
                        #1;
                        check("abort.mem_req", 32'(mem_req), 32'd0);
                        check("abort.mem_we", 32'(mem_we), 32'd0);
                        check("abort.instr_done", 32'(instr_done), 32'd0);
                        check("abort.state", 32'(state), 32'(ST_RESET));
                        do_reset();
                        return;
                    end
                    e.instr_done = 1'b1;
                    step("mem_wr_ack", 1'b1, ST_MEM_WR, e);
                end
            end
            K_CBZ: begin
                zero = z;
                e = '0; e.alu_op = 2'b01; e.reg2_loc = 1'b1; e.instr_done = 1'b1;
                e.pc_src = 1'b1; e.pc_write = z;
                step("cbz", 1'($urandom), ST_CBZ, e);
            end
            K_B: begin
                e = '0; e.pc_src = 1'b1; e.pc_write = 1'b1; e.instr_done = 1'b1;
                step("br", 1'($urandom), ST_BR, e);
            end
            default: ;
        endcase
    endtask

    function automatic logic [10:0] rand_opcode();
        logic [10:0] op;
        case ($urandom_range(0, 5))
            0: case ($urandom_range(0, 3))
                   0: op = 11'h458;
                   1: op = 11'h658;
                   2: op = 11'h450;
                   default: op = 11'h550;
               endcase
            1: op = 11'h7C2;
            2: op = 11'h7C0;
            3: op = {8'hB4, 3'($urandom)};
            4: op = {6'h05, 5'($urandom)};
            default: begin
                op = 11'($urandom);
                while (classify(op) != K_ILL) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    initial begin
        rst_n   = 1'b0;
        opcode  = '0;
        zero    = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(11'h458, 0, 0, 1'b0, 1'b0);
        run_instr(11'h7C2, 0, 2, 1'b0, 1'b0);
        run_instr(11'h5A3, 0, 0, 1'b1, 1'b0);
        run_instr(11'h5A3, 0, 0, 1'b0, 1'b0);
        run_instr(11'h0A0, 0, 0, 1'b0, 1'b0);
        run_instr(11'h7FF, 0, 0, 1'b0, 1'b0);
        run_instr(11'h7C0, 1, 1, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++)
            run_instr(rand_opcode(), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'b0);

        run_instr(11'h7C0, 0, 2, 1'b0, 1'b1);
        run_instr(11'h458, 1, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
